rx_recirc: RTL
==============

# rx_recirc

Per-output-port receiver for the speculative recirculating network. It is the receiving end of the `tx_recirc` path: it captures flits leaving the photonic switch on one output port and screens out misrouted flits. It buffers accepted flits in a small show-ahead FIFO, presents them to the downstream sink under a valid/ready handshake, and keeps delivery statistics for the emulation top level. One instance is placed per port on the `flit_out` side of `network`.

## Interface
Parameters:
- `PORT_ID`, default 0: output port index this receiver serves; compared against `din.dest`.
- `DEPTH`, default 4: FIFO entries; a power of 2 and at least 2.
- `CNT_W`, default 32: width of every statistics counter.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `din`  in  packet_t  flit from switch output; fields used are `valid`, `source`, `dest`, `data`, `timestamp`.
- `time_now`  in  `TIME_BITS`  global emulation time, the same counter that stamps `timestamp` at injection.
- `dout`  out  packet_t  FIFO head; `dout.valid`=1 iff FIFO non-empty.
- `ready`  in  1  sink accepts `dout` this cycle.
- `full`  out  1  occupancy == `DEPTH`.
- `nearly_full`  out  1  occupancy >= `DEPTH`-1.
- `pkt_count`  out  `CNT_W`  flits delivered (popped).
- `lat_sum`  out  `CNT_W`  sum of delivery latencies.
- `misroute_count`  out  `CNT_W`  valid flits with `dest` != `PORT_ID`.
- `drop_count`  out  `CNT_W`  valid, correctly routed flits refused because the FIFO was full.

## Operation
- Push: when `din.valid` && `din.dest`==`PORT_ID` && !`full`, `din` is written at the write pointer.
- Misroute: when `din.valid` && `din.dest`!=`PORT_ID`, the flit is discarded and `misroute_count`++. This applies whatever the FIFO state is.
- Overflow: when the flit is correctly routed and `full`=1, the flit is discarded and `drop_count`++.
  - A push is refused when `full` even if a pop occurs in the same cycle, because `full` is what upstream was shown.
- Pop: when `dout.valid` && `ready`:
  - Read pointer advances.
  - `pkt_count`++.
  - `lat_sum` += (`time_now` - `dout.timestamp`) mod 2^`TIME_BITS`, zero-extended to `CNT_W`.
- Simultaneous push and pop with 0 < occupancy < `DEPTH`: both take effect and occupancy is unchanged.
- Empty FIFO:
  - `ready` is ignored.
  - `dout` is driven all-zero, with `valid`=0.
- Pointers are log2(`DEPTH`)+1 bits wide and wrap naturally. Empty means the pointers are equal; full means the MSBs differ and the rest are equal.
- All counters saturate at 2^`CNT_W`-1 and never wrap. `lat_sum` saturates instead of overflowing.
- Reset (any time, including mid-transfer):
  - Pointers are cleared and FIFO contents are logically discarded.
  - All counters go to 0.
  - `dout.valid`=0, `full`=0, `nearly_full`=0.
  - Memory contents need not be cleared.
- A flit present on `din` during reset is lost and is not counted.

## Timing
- Flit accepted at edge N is visible on `dout` after edge N, i.e. during cycle N+1 (1-cycle latency).
- `dout` is a show-ahead head taken combinationally from memory plus the read pointer. There is no extra output register.
- `full` and `nearly_full` are derived from registered pointers, so they are valid from the start of each cycle. Upstream back-pressure (OEO/tx) sees the occupancy as of the previous edge.
- Counters update on the same edge as the event that increments them. The counter outputs are registered.
- `lat_sum` uses the `time_now` value at the pop edge.

## Structure
- packet_t, `PORTS`, `TIME_BITS` come from the shared `config.sv` package. No new typedefs are needed there.
- Add `RX_DEPTH` and `STAT_W` defines to the shared config so that `network` can instantiate receivers uniformly.
- One sub-module, `rx_fifo`: a parameterised show-ahead FIFO with push, pop, full, nearly_full, empty and asynchronous active-low reset.
- Accept/discard classification and the statistics counters stay in `rx_recirc`.

## Test plan
1. Reset then idle: after `rst` is released, all outputs are 0 and `dout.valid`=0. `ready`=1 with no input leaves counters at 0.
2. Single delivery: `PORT_ID`=2, inject dest=2 with timestamp=10 at a cycle where `time_now`=12, `ready`=1.
   - `dout` is valid on the next cycle with matching data.
   - After the pop edge (`time_now`=13): `pkt_count`=1, `lat_sum`=3.
3. Misroute: inject dest=1 into `PORT_ID`=2 → `misroute_count`=1, `dout.valid` stays 0, no FIFO change.
4. Fill and overflow: `DEPTH`=4, `ready`=0, inject 6 correct flits on consecutive cycles.
   - `nearly_full` rises after the 3rd flit and `full` after the 4th.
   - `drop_count`=2.
   - Draining yields exactly the first 4 flits in order.
5. Full with concurrent pop: FIFO full, `ready`=1, inject a correct flit.
   - Flit is dropped (`drop_count`++).
   - Occupancy becomes 3 and `full` falls.
6. Latency wrap and mid-run reset:
   - timestamp=2^`TIME_BITS`-2, pop when `time_now`=1 → `lat_sum` += 3.
   - Then assert `rst` with 2 flits queued → `dout.valid`=0 immediately (asynchronous) and all counters are 0.

Source files
------------

// File: rtl/rx_recirc_pkg.sv
// rx_recirc_pkg: shared types and sizing for the recirculating-network receiver.
//   packet_t  - flit as it leaves the photonic switch
//   PORTS     - number of switch output ports
//   TIME_BITS - width of the global emulation time counter / flit timestamp
//   RX_DEPTH  - default receiver FIFO depth, so network can instantiate uniformly
//   STAT_W    - default statistics counter width
package rx_recirc_pkg;

   localparam int PORTS     = 4;
   localparam int PORT_W    = $clog2(PORTS);
   localparam int DATA_W    = 32;
   localparam int TIME_BITS = 16;
   localparam int RX_DEPTH  = 4;
   localparam int STAT_W    = 32;

   typedef struct packed {
      logic                 valid;
      logic [PORT_W-1:0]    source;
      logic [PORT_W-1:0]    dest;
      logic [DATA_W-1:0]    data;
      logic [TIME_BITS-1:0] timestamp;
   } packet_t;

   // Delivery latency; the time counter wraps, so the difference is taken modulo 2^TIME_BITS.
   function automatic logic [TIME_BITS-1:0] flit_latency(input logic [TIME_BITS-1:0] now,
                                                         input logic [TIME_BITS-1:0] stamp);
      return now - stamp;
   endfunction

endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: parameterised show-ahead FIFO.
//   clk, rst       - clock, asynchronous active-low reset
//   i_push/i_wdata - write request and data (ignored when full)
//   i_pop          - read request (ignored when empty)
//   o_rdata        - head entry, combinational from memory and read pointer
//   o_full         - occupancy == DEPTH
//   o_nearly_full  - occupancy >= DEPTH-1
//   o_empty        - occupancy == 0
module rx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_nearly_full,
   output logic             o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] NF_THR = (AW + 1)'(DEPTH - 1);

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic        w_push;
   logic        w_pop;
   logic [AW:0] w_count;

   assign o_empty       = (r_wptr == r_rptr);
   assign o_full        = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_count       = r_wptr - r_rptr;
   assign o_nearly_full = (w_count >= NF_THR);

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop & ~o_empty;

   assign o_rdata = r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // Storage is not reset; clearing the pointers discards its contents logically.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/rx_recirc.sv
// rx_recirc: per-output-port receiver of the recirculating network.
// Screens out misrouted flits, buffers accepted flits in a show-ahead FIFO and
// keeps saturating delivery statistics.
//   clk, rst       - clock, asynchronous active-low reset
//   din            - flit from the switch output port
//   time_now       - global emulation time
//   dout, ready    - FIFO head to the sink (valid iff non-empty) and sink accept
//   full           - FIFO occupancy == DEPTH (registered pointers)
//   nearly_full    - FIFO occupancy >= DEPTH-1
//   pkt_count      - flits delivered
//   lat_sum        - sum of delivery latencies
//   misroute_count - valid flits with dest != PORT_ID
//   drop_count     - correctly routed flits refused because the FIFO was full
module rx_recirc
   import rx_recirc_pkg::*;
#(
   parameter int unsigned PORT_ID = 0,
   parameter int unsigned DEPTH   = RX_DEPTH,
   parameter int unsigned CNT_W   = STAT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  packet_t              din,
   input  logic [TIME_BITS-1:0] time_now,
   output packet_t              dout,
   input  logic                 ready,
   output logic                 full,
   output logic                 nearly_full,
   output logic [CNT_W-1:0]     pkt_count,
   output logic [CNT_W-1:0]     lat_sum,
   output logic [CNT_W-1:0]     misroute_count,
   output logic [CNT_W-1:0]     drop_count
);

   localparam int unsigned PW    = $bits(packet_t);
   // Wide enough for both operands plus a carry, so the saturation test sees any overflow.
   localparam int unsigned SUM_W = ((CNT_W > TIME_BITS) ? CNT_W : TIME_BITS) + 1;
   localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

   logic [PW-1:0]        w_rdata;
   packet_t              w_head;
   logic                 w_empty;
   logic                 w_full;
   logic                 w_for_me;
   logic                 w_accept;
   logic                 w_misroute;
   logic                 w_drop;
   logic                 w_pop;
   logic [TIME_BITS-1:0] w_lat;
   logic [SUM_W-1:0]     w_lat_wide;

   logic [CNT_W-1:0] r_pkt_count, w_pkt_count;
   logic [CNT_W-1:0] r_lat_sum, w_lat_sum;
   logic [CNT_W-1:0] r_misroute_count, w_misroute_count;
   logic [CNT_W-1:0] r_drop_count, w_drop_count;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Classification of the incoming flit. Drop uses the registered full flag:
   // a same-cycle pop does not make room, since upstream already saw full.
   assign w_for_me   = (din.dest == PORT_W'(PORT_ID));
   assign w_misroute = din.valid & ~w_for_me;
   assign w_accept   = din.valid & w_for_me & ~w_full;
   assign w_drop     = din.valid & w_for_me & w_full;
   assign w_pop      = ~w_empty & ready;

   rx_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (PW)
   ) u_fifo (
      .clk           (clk),
      .rst           (rst),
      .i_push        (w_accept),
      .i_wdata       (din),
      .i_pop         (w_pop),
      .o_rdata       (w_rdata),
      .o_full        (w_full),
      .o_nearly_full (nearly_full),
      .o_empty       (w_empty)
   );

   assign w_head = packet_t'(w_rdata);
   assign dout   = w_empty ? packet_t'('0) : w_head;
   assign full   = w_full;

   assign w_lat      = flit_latency(time_now, w_head.timestamp);
   assign w_lat_wide = SUM_W'(r_lat_sum) + SUM_W'(w_lat);

   always_comb begin
      w_pkt_count      = r_pkt_count;
      w_lat_sum        = r_lat_sum;
      w_misroute_count = r_misroute_count;
      w_drop_count     = r_drop_count;
      if (w_pop) begin
         w_pkt_count = sat_inc(r_pkt_count);
         w_lat_sum   = (w_lat_wide > CNT_MAX) ? {CNT_W{1'b1}} : w_lat_wide[CNT_W-1:0];
      end
      if (w_misroute) w_misroute_count = sat_inc(r_misroute_count);
      if (w_drop)     w_drop_count     = sat_inc(r_drop_count);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pkt_count      <= '0;
         r_lat_sum        <= '0;
         r_misroute_count <= '0;
         r_drop_count     <= '0;
      end else begin
         r_pkt_count      <= w_pkt_count;
         r_lat_sum        <= w_lat_sum;
         r_misroute_count <= w_misroute_count;
         r_drop_count     <= w_drop_count;
      end
   end

   assign pkt_count      = r_pkt_count;
   assign lat_sum        = r_lat_sum;
   assign misroute_count = r_misroute_count;
   assign drop_count     = r_drop_count;

endmodule
